// File: rtl/immediate_if.sv
// immediate_if: beat handshake and decoded-immediate bus for immediate_unit
interface immediate_if #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 5
);
  logic                 valid_in;
  logic                 ready_in;
  logic [31:0]          instruction;
  logic [2:0]           instruction_type;
  logic                 compressed;
  logic [3:0]           c_format;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 valid_out;
  logic                 ready_out;
  logic [XLEN-1:0]      immediate;
  logic                 illegal;
  logic [TAG_WIDTH-1:0] tag_out;
  logic [7:0]           illegal_count;
  modport master (
    output valid_in, instruction, instruction_type, compressed, c_format, tag_in, ready_out,
    input  ready_in, valid_out, immediate, illegal, tag_out, illegal_count
  );
  modport slave (
    input  valid_in, instruction, instruction_type, compressed, c_format, tag_in, ready_out,
    output ready_in, valid_out, immediate, illegal, tag_out, illegal_count
  );
endinterface

// File: rtl/immediate_unit.sv
// immediate_unit: RISC-V (incl. RVC) immediate decoder behind a 2-entry skid buffer
module immediate_unit #(
  parameter int XLEN       = 32,
  parameter bit RVC_ENABLE = 1,
  parameter int TAG_WIDTH  = 5
) (
  input logic         clk,
  input logic         reset,
  immediate_if.slave  io_bus
);
  logic [31:0]          w_i;
  logic [31:0]          w_raw;
  logic                 w_ill;
  logic [XLEN-1:0]      w_imm;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_load;
  logic                 w_s_nxt;
  logic                 r_vld;
  logic                 r_ill;
  logic [XLEN-1:0]      r_imm;
  logic [TAG_WIDTH-1:0] r_tag;
  logic                 r_s_vld;
  logic                 r_s_ill;
  logic [XLEN-1:0]      r_s_imm;
  logic [TAG_WIDTH-1:0] r_s_tag;
  logic                 r_rdy;
  logic [7:0]           r_cnt;
  assign w_i = io_bus.instruction;
  // Every format is built as a 32-bit value already extended to bit 31; widening is then a plain sign extension
  always_comb begin
    w_raw = '0;
    if (io_bus.compressed)
      case (io_bus.c_format)
        4'd0: w_raw = {{26{w_i[12]}}, w_i[12], w_i[6:2]};
        4'd1: w_raw = {{14{w_i[12]}}, w_i[12], w_i[6:2], 12'b0};
        4'd2: w_raw = {{22{w_i[12]}}, w_i[12], w_i[4:3], w_i[5], w_i[2], w_i[6], 4'b0};
        4'd3: w_raw = {22'b0, w_i[10:7], w_i[12:11], w_i[5], w_i[6], 2'b0};
        4'd4: w_raw = {25'b0, w_i[5], w_i[12:10], w_i[6], 2'b0};
        4'd5: w_raw = {24'b0, w_i[8:7], w_i[12:9], 2'b0};
        4'd6: w_raw = {24'b0, w_i[3:2], w_i[12], w_i[6:4], 2'b0};
        4'd7: w_raw = {{20{w_i[12]}}, w_i[12], w_i[8], w_i[10:9], w_i[6], w_i[7], w_i[2], w_i[11], w_i[5:3], 1'b0};
        4'd8: w_raw = {{23{w_i[12]}}, w_i[12], w_i[6:5], w_i[2], w_i[11:10], w_i[4:3], 1'b0};
        default: w_raw = '0;
      endcase
    else
      case (io_bus.instruction_type)
        3'd1: w_raw = {{20{w_i[31]}}, w_i[31:20]};
        3'd2: w_raw = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
        3'd3: w_raw = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
        3'd4: w_raw = {w_i[31:12], 12'b0};
        3'd5: w_raw = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
        default: w_raw = '0;
      endcase
  end
  assign w_ill   = io_bus.compressed ? (!RVC_ENABLE || io_bus.c_format > 4'd8) : (io_bus.instruction_type > 3'd5);
  assign w_imm   = w_ill ? '0 : XLEN'($signed(w_raw));
  assign w_push  = io_bus.valid_in && r_rdy;
  assign w_pop   = r_vld && io_bus.ready_out;
  assign w_load  = !r_vld || w_pop;
  // A push can never meet a full skid, since ready_in is low whenever the skid holds a beat
  assign w_s_nxt = !w_load && (r_s_vld || w_push);
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vld   <= 1'b0;
      r_ill   <= 1'b0;
      r_imm   <= '0;
      r_tag   <= '0;
      r_s_vld <= 1'b0;
      r_s_ill <= 1'b0;
      r_s_imm <= '0;
      r_s_tag <= '0;
      r_rdy   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_rdy   <= !w_s_nxt;
      r_s_vld <= w_s_nxt;
      if (w_load) begin
        r_vld <= r_s_vld || w_push;
        if (r_s_vld) begin
          r_ill <= r_s_ill;
          r_imm <= r_s_imm;
          r_tag <= r_s_tag;
        end else if (w_push) begin
          r_ill <= w_ill;
          r_imm <= w_imm;
          r_tag <= io_bus.tag_in;
        end
      end else if (w_push) begin
        r_s_ill <= w_ill;
        r_s_imm <= w_imm;
        r_s_tag <= io_bus.tag_in;
      end
      if (w_push && w_ill && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end
  assign io_bus.ready_in      = r_rdy;
  assign io_bus.valid_out     = r_vld;
  assign io_bus.immediate     = r_imm;
  assign io_bus.illegal       = r_ill;
  assign io_bus.tag_out       = r_tag;
  assign io_bus.illegal_count = r_cnt;
endmodule

// File: tb/tb_immediate_unit.sv
// tb_immediate_unit: randomized and directed checks of immediate_unit (XLEN 32 and 64) against a queue model
module tb_immediate_unit;
  typedef struct {
    logic [63:0] imm;
    bit          ill;
    logic [4:0]  tag;
  } beat_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        vin = 0;
  logic        rout = 0;
  logic [31:0] inst = 0;
  logic [2:0]  ty = 0;
  logic        comp = 0;
  logic [3:0]  fmt = 0;
  logic [4:0]  tag = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          ncyc = 0;
  beat_t       q[$];
  int          popped[$];
  int          exp_cnt = 0;
  bit          after_rst = 1;
  bit          acc;
  immediate_if #(.XLEN(32), .TAG_WIDTH(5)) bus32 ();
  immediate_if #(.XLEN(64), .TAG_WIDTH(5)) bus64 ();
  assign bus32.valid_in = vin;          assign bus64.valid_in = vin;
  assign bus32.ready_out = rout;        assign bus64.ready_out = rout;
  assign bus32.instruction = inst;      assign bus64.instruction = inst;
  assign bus32.instruction_type = ty;   assign bus64.instruction_type = ty;
  assign bus32.compressed = comp;       assign bus64.compressed = comp;
  assign bus32.c_format = fmt;          assign bus64.c_format = fmt;
  assign bus32.tag_in = tag;            assign bus64.tag_in = tag;
  immediate_unit #(.XLEN(32), .RVC_ENABLE(1), .TAG_WIDTH(5)) dut32 (.clk(clk), .reset(rst_n), .io_bus(bus32));
  immediate_unit #(.XLEN(64), .RVC_ENABLE(1), .TAG_WIDTH(5)) dut64 (.clk(clk), .reset(rst_n), .io_bus(bus64));
  always #5 clk = ~clk;
  function automatic longint gb(logic [31:0] x, int hi, int lo);
    longint v = longint'(x >> lo);
    return v & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction
  function automatic longint sx(longint x, int n);
    return x[n-1] ? x - (longint'(1) << n) : x;
  endfunction
  function automatic bit ref_ill(logic [2:0] t, bit c, logic [3:0] f);
    return c ? (f > 8) : (t > 5);
  endfunction
  function automatic longint ref_imm(logic [31:0] x, logic [2:0] t, bit c, logic [3:0] f);
    if (ref_ill(t, c, f)) return 0;
    if (c)
      case (f)
        0: return sx(gb(x,12,12) << 5 | gb(x,6,2), 6);
        1: return sx(gb(x,12,12) << 17 | gb(x,6,2) << 12, 18);
        2: return sx(gb(x,12,12) << 9 | gb(x,6,6) << 4 | gb(x,5,5) << 6 | gb(x,4,3) << 7 | gb(x,2,2) << 5, 10);
        3: return gb(x,12,11) << 4 | gb(x,10,7) << 6 | gb(x,6,6) << 2 | gb(x,5,5) << 3;
        4: return gb(x,12,10) << 3 | gb(x,6,6) << 2 | gb(x,5,5) << 6;
        5: return gb(x,12,9) << 2 | gb(x,8,7) << 6;
        6: return gb(x,12,12) << 5 | gb(x,6,4) << 2 | gb(x,3,2) << 6;
        7: return sx(gb(x,12,12) << 11 | gb(x,11,11) << 4 | gb(x,10,9) << 8 | gb(x,8,8) << 10 |
                     gb(x,7,7) << 6 | gb(x,6,6) << 7 | gb(x,5,3) << 1 | gb(x,2,2) << 5, 12);
        8: return sx(gb(x,12,12) << 8 | gb(x,11,10) << 3 | gb(x,6,5) << 6 | gb(x,4,3) << 1 | gb(x,2,2) << 5, 9);
        default: return 0;
      endcase
    case (t)
      1: return sx(gb(x,31,20), 12);
      2: return sx(gb(x,31,25) << 5 | gb(x,11,7), 12);
      3: return sx(gb(x,31,31) << 12 | gb(x,7,7) << 11 | gb(x,30,25) << 5 | gb(x,11,8) << 1, 13);
      4: return sx(gb(x,31,12) << 12, 32);
      5: return sx(gb(x,31,31) << 20 | gb(x,19,12) << 12 | gb(x,20,20) << 11 | gb(x,30,21) << 1, 21);
      default: return 0;
    endcase
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask
  // Model: beats in flight form a FIFO; the unit holds at most two of them
  always @(posedge clk) begin
    ncyc++;
    if (!rst_n) begin
      q.delete();
      exp_cnt = 0;
      after_rst = 1;
    end else begin
      acc = vin && !after_rst && q.size() < 2;
      if (q.size() > 0 && rout) void'(q.pop_front());
      if (acc) begin
        q.push_back('{imm: ref_imm(inst, ty, comp, fmt), ill: ref_ill(ty, comp, fmt), tag: tag});
        if (ref_ill(ty, comp, fmt) && exp_cnt < 255) exp_cnt++;
      end
      after_rst = 0;
    end
  end
  always @(negedge clk) begin
    if (ncyc > 0) begin
      chk("ready_in32", bus32.ready_in, !after_rst && q.size() < 2);
      chk("ready_in64", bus64.ready_in, !after_rst && q.size() < 2);
      chk("valid_out32", bus32.valid_out, q.size() > 0);
      chk("valid_out64", bus64.valid_out, q.size() > 0);
      chk("illegal_count32", bus32.illegal_count, exp_cnt);
      chk("illegal_count64", bus64.illegal_count, exp_cnt);
      if (after_rst) begin
        chk("rst_imm", bus64.immediate, 0);
        chk("rst_illegal", bus32.illegal, 0);
        chk("rst_tag", bus32.tag_out, 0);
      end
      if (q.size() > 0) begin
        chk("imm32", bus32.immediate, q[0].imm[31:0]);
        chk("imm64", bus64.immediate, q[0].imm);
        chk("illegal", bus32.illegal, q[0].ill);
        chk("tag", bus32.tag_out, q[0].tag);
        chk("tag64", bus64.tag_out, q[0].tag);
      end
      if (bus32.valid_out && rout) popped.push_back(int'(bus32.tag_out));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send1(input logic [2:0] t, input bit c, input logic [3:0] f, input logic [31:0] x, input logic [4:0] g);
    vin = 1; ty = t; comp = c; fmt = f; inst = x; tag = g; rout = 1;
    step();
    vin = 0;
  endtask
  initial begin
    chk("ref_I", ref_imm(32'hFFF00093, 1, 0, 0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_S", ref_imm(32'hFE000FA3, 2, 0, 0), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ref_J", ref_imm(32'h8000006F, 5, 0, 0), 64'hFFFF_FFFF_FFF0_0000);
    chk("ref_CB", ref_imm(32'h00001000, 0, 1, 8), 64'hFFFF_FFFF_FFFF_FF00);
    chk("ref_CIW", ref_imm(32'h00001FE0, 0, 1, 3), 64'h3FC);
    chk("ref_LWSP", ref_imm(32'h000050FD, 0, 1, 6), 64'hFC);
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
    step();
    chk("rdy_after_reset", bus32.ready_in, 1);
    send1(1, 0, 0, 32'hFFF00093, 3);
    chk("I_valid", bus32.valid_out, 1);
    chk("I_imm32", bus32.immediate, 32'hFFFF_FFFF);
    chk("I_illegal", bus32.illegal, 0);
    step();
    send1(4, 0, 0, 32'h800000B7, 4);
    chk("U_imm64", bus64.immediate, 64'hFFFF_FFFF_8000_0000);
    chk("U_imm32", bus32.immediate, 32'h8000_0000);
    step();
    send1(0, 1, 0, 32'h000050FD, 5);
    chk("CI_imm32", bus32.immediate, 32'hFFFF_FFFF);
    step();
    send1(0, 1, 6, 32'hABCD50FD, 6);
    chk("LWSP_imm32", bus32.immediate, 32'h0000_00FC);
    step();
    rout = 0; vin = 1; ty = 1; comp = 0; tag = 1;
    step();
    tag = 2;
    step();
    chk("skid_rdy_low", bus32.ready_in, 0);
    tag = 3;
    step();
    chk("skid_rdy_still_low", bus32.ready_in, 0);
    chk("skid_head_tag", bus32.tag_out, 1);
    popped.delete();
    rout = 1;
    repeat (2) step();
    vin = 0;
    repeat (2) step();
    chk("order_count", popped.size(), 3);
    foreach (popped[i]) chk("order_tag", popped[i], i + 1);
    send1(7, 0, 0, $urandom, 9);
    chk("ill_imm", bus32.immediate, 0);
    chk("ill_flag", bus32.illegal, 1);
    chk("ill_tag", bus32.tag_out, 9);
    chk("ill_cnt1", bus32.illegal_count, 1);
    vin = 1;
    repeat (299) step();
    vin = 0;
    step();
    chk("ill_cnt_sat", bus32.illegal_count, 255);
    rout = 0; vin = 1; ty = 1; tag = 1;
    step();
    tag = 2;
    step();
    chk("full_rdy", bus32.ready_in, 0);
    rst_n = 0; vin = 0;
    step();
    chk("rst_valid", bus32.valid_out, 0);
    chk("rst_cnt", bus32.illegal_count, 0);
    chk("rst_rdy", bus32.ready_in, 0);
    rst_n = 1;
    step();
    chk("rel_rdy", bus32.ready_in, 1);
    chk("rel_valid", bus32.valid_out, 0);
    send1(1, 0, 0, 32'h00500093, 5);
    chk("post_rst_valid", bus32.valid_out, 1);
    chk("post_rst_tag", bus32.tag_out, 5);
    chk("post_rst_imm", bus32.immediate, 5);
    step();
    for (int n = 0; n < 2000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      vin = ($urandom_range(0, 3) != 0);
      rout = ($urandom_range(0, 3) != 0);
      comp = $urandom_range(0, 1);
      inst = $urandom;
      tag = 5'($urandom_range(0, 31));
      ty = comp ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
      fmt = 4'($urandom_range(0, 10));
      step();
    end
    rst_n = 1; vin = 0; rout = 1;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/immediate_unit.md
IMMEDIATE_UNIT -- requirements
Module: immediate_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; only 32 and 64 are legal.
REQ-002 SHALL have parameter RVC_ENABLE, default 1; when 1, compressed (RVC) immediates are decoded.
REQ-003 SHALL have parameter TAG_WIDTH, default 5, width of the sideband tag carried with each beat.
REQ-004 SHALL have a single clock, clk (input, 1): all state updates on its rising edge.
REQ-005 SHALL have reset (input, 1): synchronous, active-low.
REQ-006 SHALL have valid_in (input, 1): the upstream beat is valid.
REQ-007 SHALL have ready_in (output, 1): the unit can accept a beat.
REQ-008 SHALL have instruction (input, 32): the raw instruction; bits [15:0] only when compressed=1.
REQ-009 SHALL have instruction_type (input, 3), using the Defines.v codes: R_TYPE=0, I_TYPE=1, S_TYPE=2, B_TYPE=3, U_TYPE=4, J_TYPE=5.
REQ-010 SHALL have compressed (input, 1): select RVC decoding via c_format.
REQ-011 SHALL have c_format (input, 4): 0 CI, 1 CI_LUI, 2 CI_16SP, 3 CIW, 4 CL_W, 5 CSS_W, 6 CI_LWSP, 7 CJ, 8 CB.
REQ-012 SHALL have tag_in (input, TAG_WIDTH): sideband data, passed through unchanged.
REQ-013 SHALL have valid_out (output, 1) and ready_out (input, 1): the downstream handshake.
REQ-014 SHALL have immediate (output, XLEN), illegal (output, 1) and tag_out (output, TAG_WIDTH).
REQ-015 SHALL have illegal_count (output, 8): saturating count of accepted illegal beats.

Function
REQ-016 SHALL accept a beat when valid_in && ready_in, and present it at valid_out on the next cycle (latency 1).
REQ-017 SHALL sustain 1 beat/cycle while ready_out=1.
REQ-018 SHALL buffer beats in a 2-entry skid (main and skid registers); ready_in = !skid_full, registered.
REQ-019 SHALL, when valid_out && !ready_out and a beat is accepted, place that beat in the skid register; ready_in drops the following cycle.
REQ-020 SHALL preserve beat order, and SHALL hold immediate/illegal/tag_out stable while valid_out && !ready_out.
REQ-021 SHALL, on a simultaneous output pop and input push, promote the skid entry (if any) to main and buffer the new beat behind it.
REQ-022 SHALL decode 32-bit immediates, all sign-extended from bit 31 to XLEN:
- I: inst[31:20]
- S: inst[31:25|11:7]
- B: inst[31|7|30:25|11:8], with bit 0 = 0
- U: inst[31:12], with 12 zero LSBs
- J: inst[31|19:12|20|30:21], with bit 0 = 0
- R_TYPE gives immediate 0, not illegal.
REQ-023 SHALL decode RVC formats; letters S = sign-extend to XLEN, Z = zero-extend:
- CI: S, [5]=i12, [4:0]=i6:2
- CI_LUI: S, [17]=i12, [16:12]=i6:2
- CI_16SP: S, [9]=i12, [4]=i6, [6]=i5, [8:7]=i4:3, [5]=i2
- CIW: Z, [5:4]=i12:11, [9:6]=i10:7, [2]=i6, [3]=i5
- CL_W: Z, [5:3]=i12:10, [2]=i6, [6]=i5
- CSS_W: Z, [5:2]=i12:9, [7:6]=i8:7
- CI_LWSP: Z, [5]=i12, [4:2]=i6:4, [7:6]=i3:2
- CJ: S, [11]=i12, [4]=i11, [9:8]=i10:9, [10]=i8, [6]=i7, [7]=i6, [3:1]=i5:3, [5]=i2, bit 0 = 0
- CB: S, [8]=i12, [4:3]=i11:10, [7:6]=i6:5, [2:1]=i4:3, [5]=i2, bit 0 = 0
REQ-024 SHALL flag a beat illegal when instruction_type is 6/7, when c_format is >8, or when compressed=1 with RVC_ENABLE=0; an illegal beat gives immediate=0, illegal=1, and is still passed through the handshake.
REQ-025 SHALL increment illegal_count once per accepted illegal beat, saturating at 255 (no wrap).

Reset
REQ-026 SHALL, while reset=0 at a clock edge, force the following on the next cycle: valid_out=0, ready_in=0, immediate=0, illegal=0, tag_out=0, illegal_count=0, skid empty.
REQ-027 SHALL drop all buffered beats on reset mid-operation, and SHALL assert ready_in=1 on the first cycle after reset returns to 1.

Verification
REQ-028 I_TYPE, 0xFFF00093, XLEN=32 -> next cycle valid_out=1, immediate=0xFFFFFFFF, illegal=0.
REQ-029 U_TYPE, 0x800000B7, XLEN=64 -> immediate=0xFFFFFFFF80000000; RVC CI, 0x50FD -> 0xFFFFFFFF (XLEN=32); CI_LWSP, 0x50FD -> 0x000000FC.
REQ-030 ready_out=0, three beats tagged 1,2,3 offered -> tags 1,2 accepted, ready_in=0; ready_out=1 -> outputs 1,2,3 in order, with no duplicate or loss.
REQ-031 instruction_type=7, tag 9 -> immediate=0, illegal=1, tag_out=9; 300 such beats -> illegal_count=255.
REQ-032 reset=0 asserted while the skid is full -> next cycle valid_out=0, illegal_count=0; after release, ready_in=1 and the first new beat emerges with latency 1.
